mont_domain_convert: RTL
========================

Name: mont_domain_convert

Overview:
- Parametrised converter for ECC point coordinates (Px, Py) between the regular and Montgomery domains, with R = 2^RBITS.
- To-Montgomery computes x·2^RBITS mod p by RBITS modular doublings.
- From-Montgomery computes x·2^-RBITS mod p by RBITS modular halvings.
- Sits between the point-arithmetic core and its I/O. Adds valid/ready handshakes, output backpressure and operand/prime error detection.

Parameters:
- WIDTH, 32, bit width of coordinates and prime.
- RBITS, WIDTH, number of doubling/halving iterations (log2 R); must be >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  reset is synchronous and active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- to_mont  input  1  1 = to Montgomery, 0 = to regular; sampled at accept.
- px_i  input  WIDTH  x coordinate in.
- py_i  input  WIDTH  y coordinate in.
- prime  input  WIDTH  modulus p; sampled at accept.
- px_out  output  WIDTH  converted x.
- py_out  output  WIDTH  converted y.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- err  output  1  qualifies the result as invalid; meaningful only while out_valid=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, high at rising edge), from any state including mid-conversion:
  - state=IDLE, counter=0.
  - px_out=py_out=0, out_valid=0, err=0, busy=0, in_ready=1.
  - An in-flight request is discarded.
- States: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready. At the accepting edge, latch mode and p.
  - Load each operand as: x' = (x >= p) ? x - p : x.
  - Error check at accept:
    - err_nxt=1 if p is even, or p==0, or either operand >= 2p.
    - 2p is computed in WIDTH+1 bits.
  - If err_nxt: go to DONE with px_out=py_out=0, err=1, no iterations.
  - Otherwise: go to ITER, counter=0, err=0.
- ITER:
  - in_ready=0. One iteration per clock on both coordinates in parallel.
  - to_mont: s = {x,1'b0} (WIDTH+1 bits); x_nxt = (s >= p) ? s - p : s.
  - regular: if x[0], x_nxt = (x + p) >> 1 with the sum in WIDTH+1 bits; else x_nxt = x >> 1.
  - The counter increments each cycle, width clog2(RBITS+1).
  - After the RBITS-th iteration, go to DONE.
  - Invariant: x < p holds throughout ITER.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - px_out, py_out and err are stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE next edge: out_valid=0, err=0.
  - Outputs keep their last value in IDLE.
- Latency:
  - out_valid rises exactly RBITS+1 clock edges after the accepting edge.
  - Error path: out_valid rises 1 edge after accept.
  - Throughput is one request per RBITS+2 cycles when out_ready is held at 1.
- in_valid while not in IDLE is ignored. Requesters hold the request until in_ready.
- in_valid and out_ready in the same cycle while in DONE: only the output handshake completes. The new request is accepted in IDLE on a later cycle.
- Inputs px_i, py_i, prime and to_mont are don't-care except at the accepting edge.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- WIDTH=32, RBITS=32, p=0xFFFFFFFB, to_mont=1, px=1, py=2 -> out_valid 33 cycles after accept, px_out=5, py_out=10, err=0.
- Same p, to_mont=0, px=5, py=10 -> px_out=1, py_out=2. Also px=0, py=p-1 round-trips to_mont then regular unchanged.
- Input reduction: p=0xFFFFFFFB, to_mont=1, px=0xFFFFFFFC (p+1) -> px_out=5. Operand px=0xFFFFFFFF with p=0x7FFFFFFF (>= 2p) -> err=1, px_out=py_out=0, out_valid 1 cycle after accept.
- Even prime p=0x10 -> err=1, outputs 0. Next valid request converts correctly with err=0.
- Backpressure: out_ready low 10 cycles in DONE -> out_valid, px_out, py_out held stable, in_ready=0, in_valid pulses ignored. out_ready high -> IDLE next cycle.
- Reset asserted in ITER at counter=15 -> next cycle IDLE, all outputs 0, in_ready=1. Instance with WIDTH=8, RBITS=8, p=251, px=1, to_mont=1 -> px_out=5 after 9 cycles.

Source files
------------

// File: rtl/mont_domain_convert.sv
// Converts an ECC point (Px, Py) into or out of the Montgomery domain, R = 2^RBITS,
// using one modular doubling (to) or halving (from) per clock on both coordinates.
module mont_domain_convert #(
    parameter int WIDTH = 32,
    parameter int RBITS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             to_mont,
    input  logic [WIDTH-1:0] px_i,
    input  logic [WIDTH-1:0] py_i,
    input  logic [WIDTH-1:0] prime,
    output logic [WIDTH-1:0] px_out,
    output logic [WIDTH-1:0] py_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(RBITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t                     state_reg, state_next;
    logic [CW-1:0]              cnt_reg, cnt_next;
    logic                       mode_reg, mode_next;
    logic [WIDTH-1:0]           p_reg, p_next;
    logic [1:0][WIDTH-1:0]      work_reg, work_next;
    logic [WIDTH-1:0]           px_out_reg, px_out_next;
    logic [WIDTH-1:0]           py_out_reg, py_out_next;
    logic                       err_reg, err_next;

    logic [1:0][WIDTH-1:0]      op_in;
    logic [1:0][WIDTH-1:0]      op_load;
    logic [1:0][WIDTH-1:0]      op_step;
    logic [1:0]                 op_big;
    logic [WIDTH:0]             two_p;
    logic                       last_iter;

    assign op_in[0]  = px_i;
    assign op_in[1]  = py_i;
    assign two_p     = {prime, 1'b0};
    assign last_iter = (cnt_reg == CW'(RBITS - 1));

    // Per-coordinate datapath: input reduction, range check and one iteration step.
    // Since work < p, doubling stays below 2p so one subtraction reduces it fully.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [WIDTH:0] dbl;
            logic [WIDTH:0] p_ext;

            assign dbl   = {work_reg[gi], 1'b0};
            assign p_ext = {1'b0, p_reg};

            assign op_big[gi]  = ({1'b0, op_in[gi]} >= two_p);
            assign op_load[gi] = (op_in[gi] >= prime) ? (op_in[gi] - prime) : op_in[gi];

            assign op_step[gi] = mode_reg
                ? ((dbl >= p_ext) ? WIDTH'(dbl - p_ext) : dbl[WIDTH-1:0])
                : (work_reg[gi][0] ? WIDTH'(({1'b0, work_reg[gi]} + p_ext) >> 1)
                                   : {1'b0, work_reg[gi][WIDTH-1:1]});
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mode_next   = mode_reg;
        p_next      = p_reg;
        work_next   = work_reg;
        px_out_next = px_out_reg;
        py_out_next = py_out_reg;
        err_next    = err_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    mode_next = to_mont;
                    p_next    = prime;
                    cnt_next  = '0;
                    work_next = op_load;
                    // An even (or zero) modulus has no inverse of 2; flag it with bad operands.
                    if (!prime[0] || (op_big != 2'b00)) begin
                        state_next  = DONE;
                        px_out_next = '0;
                        py_out_next = '0;
                        err_next    = 1'b1;
                    end else begin
                        state_next = ITER;
                        err_next   = 1'b0;
                    end
                end
            end
            ITER: begin
                work_next = op_step;
                cnt_next  = cnt_reg + CW'(1);
                if (last_iter) begin
                    state_next  = DONE;
                    px_out_next = op_step[0];
                    py_out_next = op_step[1];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    err_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mode_reg   <= 1'b0;
            p_reg      <= '0;
            work_reg   <= '0;
            px_out_reg <= '0;
            py_out_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mode_reg   <= mode_next;
            p_reg      <= p_next;
            work_reg   <= work_next;
            px_out_reg <= px_out_next;
            py_out_reg <= py_out_next;
            err_reg    <= err_next;
        end
    end

    // All handshake outputs come straight from registers.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign px_out    = px_out_reg;
    assign py_out    = py_out_reg;
    assign err       = err_reg;

endmodule
